// File: rtl/ram_write_serializer_4w_pkg.sv
// Shared definitions for the write-side serializer of the 16-deep
// multi-read/single-write register-file RAMs.
//   NPORT      : number of independent write request ports
//   port_vec_t : one bit per request port (valid, ready, grant, pending)
//   age_mat_t  : age matrix, [i][j] = 1 means slot i was accepted before slot j
// The request payload struct (addr, data) depends on the instantiating
// module's ADDR_W/WIDTH, so it is declared inside that module.
package ram_write_serializer_4w_pkg;

  localparam int NPORT = 4;

  typedef logic [NPORT-1:0] port_vec_t;
  typedef logic [NPORT-1:0][NPORT-1:0] age_mat_t;

endpackage

// File: rtl/ram_write_serializer_4w_age_matrix_arbiter_4.sv
// Age-matrix arbiter for four in-order slots.
// Grants the oldest requesting slot; tracks relative acceptance order of
// occupied slots in an age matrix.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the matrix)
//   req        : slots competing this cycle (one-hot grant among them)
//   occ        : slots currently occupied (pending)
//   alloc      : slots loaded with a new entry at the next edge
//   grant      : one-hot grant of the oldest requester, or zero
//   older      : age matrix state, [i][j] = 1 means slot i is older than j
// Parameter LOW_FIRST picks the same-cycle tiebreak: 1 makes the lower
// index older among simultaneous allocations.
module age_matrix_arbiter_4
  import ram_write_serializer_4w_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  port_vec_t req,
  input  port_vec_t occ,
  input  port_vec_t alloc,
  output port_vec_t grant,
  output age_mat_t  older
);

  age_mat_t older_q;
  age_mat_t older_d;
  port_vec_t blocked;

  // A requester is blocked when any other requester is older than it.
  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int j = 0; j < NPORT; j++) begin
        if (j != i && req[j] && older_q[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
      grant[i] = req[i] && !blocked[i];
    end
  end

  // A newly allocated slot becomes younger than every slot that stays
  // occupied across the edge. Among slots allocated together, the
  // tiebreak decides. Bits involving empty slots are stale and get
  // rewritten when those slots are allocated again.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NPORT; i++) begin
      if (alloc[i]) begin
        for (int j = 0; j < NPORT; j++) begin
          if (j != i) begin
            if (occ[j] && !grant[j]) begin
              older_d[j][i] = 1'b1;
              older_d[i][j] = 1'b0;
            end else if (alloc[j]) begin
              older_d[j][i] = LOW_FIRST ? (j < i) : (j > i);
              older_d[i][j] = LOW_FIRST ? (i < j) : (i > j);
            end
          end
        end
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      older_d[i][i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  assign older = older_q;

endmodule

// File: rtl/ram_write_serializer_4w.sv
// Write-side front end for the 16-deep multi-read/single-write RAMs.
// Accepts up to four write requests per cycle into per-port pending slots
// and commits them one per cycle through the RAM write port, oldest first.
// Handshake: a transfer on port i happens at the rising clk edge where
// req_valid[i] && req_ready[i]; req_ready[i] depends only on registered
// state and wr_stall, never on req_valid.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-port write request valid
//   req_ready  : per-port ready (slot empty, or its entry commits this cycle)
//   req_addr   : per-port write address
//   req_data   : per-port write data
//   wr_stall   : downstream hold; no commit and no slot change while high
//   addrw, din : RAM write address/data (zero when wea=0)
//   wea        : RAM write enable
//   idle       : no pending slots
//   age_state  : age matrix state, for observation only
module ram_write_serializer_4w
  import ram_write_serializer_4w_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NPORT-1:0]                  req_valid,
  output logic [NPORT-1:0]                  req_ready,
  input  logic [NPORT-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NPORT-1:0][WIDTH-1:0]       req_data,
  input  logic                              wr_stall,
  output logic [ADDR_W-1:0]                 addrw,
  output logic [WIDTH-1:0]                  din,
  output logic                              wea,
  output logic                              idle,
  output age_mat_t                          age_state
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } write_req_t;

  write_req_t slot_q [NPORT];
  port_vec_t  pend_q;
  port_vec_t  cand;
  port_vec_t  grant;
  port_vec_t  accept;

  // Stall removes every slot from arbitration, which freezes commits.
  assign cand = pend_q & ~{NPORT{wr_stall}};

  age_matrix_arbiter_4 #(
    .LOW_FIRST (1'b1)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (cand),
    .occ   (pend_q),
    .alloc (accept),
    .grant (grant),
    .older (age_state)
  );

  // A slot committing this cycle can take a new request at the same edge.
  assign req_ready = ~pend_q | grant;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~grant) | accept;
    end
  end

  // Slot payload needs no reset: it is only observed while pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (accept[i]) begin
        slot_q[i] <= '{addr: req_addr[i], data: req_data[i]};
      end
    end
  end

  // Grant is one-hot or zero, so an OR-mux yields zeros when idle.
  always_comb begin
    addrw = '0;
    din   = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant[i]) begin
        addrw = addrw | slot_q[i].addr;
        din   = din | slot_q[i].data;
      end
    end
  end

  assign wea  = |grant;
  assign idle = ~|pend_q;

endmodule

// File: tb/tb_ram_write_serializer_4w.sv
module tb_ram_write_serializer_4w;
  import ram_write_serializer_4w_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 4;
  localparam int EW     = ADDR_W + WIDTH;

  logic                         clk;
  logic                         rst_n;
  logic [NPORT-1:0]             req_valid;
  logic [NPORT-1:0]             req_ready;
  logic [NPORT-1:0][ADDR_W-1:0] req_addr;
  logic [NPORT-1:0][WIDTH-1:0]  req_data;
  logic                         wr_stall;
  logic [ADDR_W-1:0]            addrw;
  logic [WIDTH-1:0]             din;
  logic                         wea;
  logic                         idle;
  age_mat_t                     age_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [EW-1:0] exp_q[$];

  ram_write_serializer_4w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_stall  (wr_stall),
    .addrw     (addrw),
    .din       (din),
    .wea       (wea),
    .idle      (idle),
    .age_state (age_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  // At the falling edge inputs are stable: commits are popped and compared,
  // then any handshake that will transfer at the next rising edge is pushed
  // (lower port first, matching the same-cycle ordering rule).
  always @(negedge clk) begin
    if (!rst_n) begin
      check("wea_in_reset", wea, 1'b0);
      exp_q.delete();
    end else begin
      if (wea) begin
        if (exp_q.size() == 0) check("unexpected_write", 1'b1, 1'b0);
        else check("sb_write", {addrw, din}, exp_q.pop_front());
      end
      for (int i = 0; i < NPORT; i++) begin
        if (req_valid[i] && req_ready[i]) exp_q.push_back({req_addr[i], req_data[i]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns 2 time units after a rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[p] = a;
    req_data[p] = d;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    req_valid = '0;
    wr_stall  = 1'b0;
    while (!idle && n < 40) begin
      tick();
      n++;
    end
    #1;
    check(tag, idle, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ready1_pat;
    logic [WIDTH-1:0] d1;
    logic xfer;

    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    wr_stall  = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #3;
    check("rst_wea", wea, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_ready", req_ready, 4'b1111);
    check("rst_addrw", addrw, '0);
    check("rst_din", din, '0);
    check("rst_age", age_state, '0);
    rst_n = 1'b1;
    #1 check("rel_wea0", wea, 1'b0);
    tick(); #1 check("rel_wea1", wea, 1'b0);
    tick(); #1 check("rel_wea2", wea, 1'b0);
    check("rel_idle", idle, 1'b1);

    // Single write on port 2.
    set_port(2, 4'h5, 32'hDEADBEEF);
    req_valid = 4'b0100;
    #1 check("single_ready", req_ready, 4'b1111);
    tick();
    req_valid = '0;
    #1 check("single_wea", wea, 1'b1);
    check("single_addrw", addrw, 4'h5);
    check("single_din", din, 32'hDEADBEEF);
    check("single_busy", idle, 1'b0);
    tick(); #1 check("single_wea_off", wea, 1'b0);
    check("single_idle", idle, 1'b1);
    check("single_addrw0", addrw, 4'h0);
    check("single_din0", din, 32'h0);

    // Four simultaneous writes to the same address: ports 0..3 in order.
    // Only the granted port is ready after acceptance.
    for (int i = 0; i < NPORT; i++) set_port(i, 4'h3, 32'(i + 1));
    req_valid = 4'b1111;
    tick();
    req_valid = '0;
    #1 check("four_ready0", req_ready, 4'b0001);
    check("four_wea0", wea, 1'b1);
    check("four_din0", din, 32'd1);
    check("four_addrw0", addrw, 4'h3);
    tick(); #1 check("four_ready1", req_ready, 4'b0011);
    check("four_din1", din, 32'd2);
    tick(); #1 check("four_ready2", req_ready, 4'b0111);
    check("four_din2", din, 32'd3);
    tick(); #1 check("four_ready3", req_ready, 4'b1111);
    check("four_din3", din, 32'd4);
    tick(); #1 check("four_done", wea, 1'b0);

    // Cross-cycle ordering: port 3 first, port 0 one cycle later under stall.
    set_port(3, 4'h7, 32'hAAAA0001);
    req_valid = 4'b1000;
    tick();
    set_port(0, 4'h7, 32'hBBBB0002);
    req_valid = 4'b0001;
    wr_stall  = 1'b1;
    #1 check("xc_stall_wea1", wea, 1'b0);
    check("xc_ready1", req_ready, 4'b0111);
    tick();
    req_valid = '0;
    #1 check("xc_stall_wea2", wea, 1'b0);
    check("xc_ready2", req_ready, 4'b0110);
    tick(); #1 check("xc_stall_wea3", wea, 1'b0);
    tick();
    wr_stall = 1'b0;
    #1 check("xc_first", din, 32'hAAAA0001);
    check("xc_ready4", req_ready, 4'b1110);
    tick(); #1 check("xc_second", din, 32'hBBBB0002);
    check("xc_ready5", req_ready, 4'b1111);
    tick(); #1 check("xc_done", wea, 1'b0);

    // Stall with all slots pending, then refill port 1 in its grant cycles.
    wr_stall = 1'b1;
    for (int i = 0; i < NPORT; i++) set_port(i, 4'(i), 32'h10 + 32'(i));
    req_valid = 4'b1111;
    #1 check("sr_ready_empty", req_ready, 4'b1111);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1 check("sr_stall_wea", wea, 1'b0);
      check("sr_stall_ready", req_ready, 4'b0000);
      tick();
    end
    wr_stall   = 1'b0;
    ready1_pat = 8'b1111_0010;
    d1         = 32'h100;
    set_port(1, 4'h9, d1);
    req_valid  = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      #1 check("sr_wea", wea, 1'b1);
      check("sr_ready1", req_ready[1], ready1_pat[k]);
      xfer = req_ready[1];
      tick();
      if (xfer) begin
        d1 = d1 + 1;
        set_port(1, 4'h9, d1);
      end
    end
    drain("sr_drain");

    // Random stress with asynchronous reset in the middle of a burst.
    for (int c = 0; c < 250; c++) begin
      tick();
      req_valid = 4'($urandom_range(0, 15));
      wr_stall  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NPORT; i++) set_port(i, 4'($urandom_range(0, 15)), $urandom);
      if (c == 120) begin
        rst_n = 1'b0;
        #1 check("mid_rst_wea", wea, 1'b0);
        check("mid_rst_idle", idle, 1'b1);
        check("mid_rst_ready", req_ready, 4'b1111);
      end
      if (c == 124) begin
        rst_n = 1'b1;
        #1 check("post_rst_wea", wea, 1'b0);
      end
    end
    drain("rand_drain");
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
